// File: rtl/cta_grid_dispatcher.sv
// -----------------------------------------------------------------------------
// cta_grid_dispatcher
//
// Purpose:
//   Initiator side of the CTA grant/done protocol. On a kernel launch it walks
//   the 3-D grid (x fastest, then y, then z) and offers one CTA descriptor per
//   cycle at most to NUM_CORES CGRA cores. Cores are picked round-robin and each
//   core is limited to MAX_CTA outstanding CTAs. Per-core done reports return
//   credit. kernel_done pulses for one cycle once every CTA has been issued and
//   reported done.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   kernel_start_valid/ready launch handshake (ready only while idle)
//   grid_dim_x/y/z           grid size, sampled on the launch handshake
//   kernel_ctx               descriptor template; cta_id is replaced per grant
//   sm_grant_valid/ready     per-core grant handshake (one-hot valid)
//   sm_grant_ctx             per-core descriptor, stable while valid is high
//   sm_done_valid/ready      per-core done handshake (ready tied high)
//   sm_done_cta_id           id of the finished CTA (informational only)
//   busy                     dispatcher is not idle
//   kernel_done              one-cycle completion pulse
//   err_spurious_done        sticky: a done arrived for a core with no CTA out
// -----------------------------------------------------------------------------

`ifndef DICE_NUM_MAX_CTA_PER_CORE
`define DICE_NUM_MAX_CTA_PER_CORE 4
`endif

package dice_pkg;
   localparam int CTA_DIM_W = 16;

   typedef struct packed {
      logic [CTA_DIM_W-1:0] z;
      logic [CTA_DIM_W-1:0] y;
      logic [CTA_DIM_W-1:0] x;
   } dice_cta_id_t;

   typedef struct packed {
      logic [31:0]  kernel_id;
      logic [31:0]  arg_base;
      dice_cta_id_t cta_id;
   } dice_cta_desc_t;
endpackage

module cta_grid_dispatcher
   import dice_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int MAX_CTA   = `DICE_NUM_MAX_CTA_PER_CORE,
   parameter int DIM_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 kernel_start_valid,
   output logic                 kernel_start_ready,
   input  logic [DIM_W-1:0]     grid_dim_x,
   input  logic [DIM_W-1:0]     grid_dim_y,
   input  logic [DIM_W-1:0]     grid_dim_z,
   input  dice_cta_desc_t       kernel_ctx,
   output logic [NUM_CORES-1:0] sm_grant_valid,
   input  logic [NUM_CORES-1:0] sm_grant_ready,
   output dice_cta_desc_t       sm_grant_ctx [NUM_CORES],
   input  logic [NUM_CORES-1:0] sm_done_valid,
   output logic [NUM_CORES-1:0] sm_done_ready,
   input  dice_cta_id_t         sm_done_cta_id [NUM_CORES],
   output logic                 busy,
   output logic                 kernel_done,
   output logic                 err_spurious_done
);

   localparam int CNT_W = 3 * DIM_W;
   localparam int OUT_W = $clog2(MAX_CTA + 1);
   localparam int RR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_CTA);
   localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);
   localparam logic [RR_W-1:0]  RR_ONE  = RR_W'(1);
   localparam logic [RR_W-1:0]  RR_LAST = RR_W'(NUM_CORES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DISPATCH,
      ST_DRAIN,
      ST_DONE
   } state_e;

   state_e                 state_q, state_d;
   logic [DIM_W-1:0]       dim_x_q, dim_x_d, dim_y_q, dim_y_d, dim_z_q, dim_z_d;
   logic [DIM_W-1:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d, cur_z_q, cur_z_d;
   logic [CNT_W-1:0]       total_q, total_d, issued_q, issued_d, done_q, done_d;
   logic [RR_W-1:0]        rr_q, rr_d;
   logic [OUT_W-1:0]       out_q [NUM_CORES];
   logic [OUT_W-1:0]       out_d [NUM_CORES];
   logic [NUM_CORES-1:0]   valid_q, valid_d;
   dice_cta_desc_t         ctx_q [NUM_CORES];
   dice_cta_desc_t         ctx_d [NUM_CORES];
   dice_cta_desc_t         tmpl_q, tmpl_d;
   logic                   err_q, err_d;
   logic                   ready_q, busy_q, kdone_q;

   logic                   hs_any;
   logic [RR_W-1:0]        hs_core;
   logic                   offer_en;
   logic                   found;
   int                     sel_core;
   dice_cta_desc_t         offer_ctx;
   logic                   unused_done_id;

   // The finished-CTA id is informational; fold it so it is visibly consumed.
   always_comb begin
      unused_done_id = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         unused_done_id = unused_done_id ^ (^sm_done_cta_id[i]);
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d  = state_q;
      dim_x_d  = dim_x_q;
      dim_y_d  = dim_y_q;
      dim_z_d  = dim_z_q;
      cur_x_d  = cur_x_q;
      cur_y_d  = cur_y_q;
      cur_z_d  = cur_z_q;
      total_d  = total_q;
      issued_d = issued_q;
      done_d   = done_q;
      rr_d     = rr_q;
      tmpl_d   = tmpl_q;
      err_d    = err_q;
      ctx_d    = ctx_q;
      hs_any   = 1'b0;
      hs_core  = '0;
      offer_en = 1'b0;
      found    = 1'b0;
      sel_core = 0;
      // A pending offer stays up until its core takes it.
      valid_d  = valid_q & ~sm_grant_ready;

      // Per-core credit: a grant and a done in the same cycle cancel out.
      // A done with nothing outstanding is flagged and otherwise ignored.
      for (int i = 0; i < NUM_CORES; i++) begin
         out_d[i] = out_q[i];
         if (valid_q[i] && sm_grant_ready[i]) begin
            hs_any   = 1'b1;
            hs_core  = RR_W'(i);
            out_d[i] = out_d[i] + OUT_ONE;
         end
         if (sm_done_valid[i]) begin
            if (out_q[i] != '0) begin
               out_d[i] = out_d[i] - OUT_ONE;
               done_d   = done_d + CNT_ONE;
            end else begin
               err_d = 1'b1;
            end
         end
      end

      if (hs_any) begin
         issued_d = issued_q + CNT_ONE;
         rr_d     = (hs_core == RR_LAST) ? '0 : hs_core + RR_ONE;
         if (cur_x_q == dim_x_q - DIM_ONE) begin
            cur_x_d = '0;
            if (cur_y_q == dim_y_q - DIM_ONE) begin
               cur_y_d = '0;
               cur_z_d = cur_z_q + DIM_ONE;
            end else begin
               cur_y_d = cur_y_q + DIM_ONE;
            end
         end else begin
            cur_x_d = cur_x_q + DIM_ONE;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (kernel_start_valid && ready_q) begin
               dim_x_d  = grid_dim_x;
               dim_y_d  = grid_dim_y;
               dim_z_d  = grid_dim_z;
               tmpl_d   = kernel_ctx;
               cur_x_d  = '0;
               cur_y_d  = '0;
               cur_z_d  = '0;
               issued_d = '0;
               done_d   = '0;
               total_d  = CNT_W'(grid_dim_x) * CNT_W'(grid_dim_y) * CNT_W'(grid_dim_z);
               if (grid_dim_x == '0 || grid_dim_y == '0 || grid_dim_z == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_DISPATCH;
                  offer_en = 1'b1;
               end
            end
         end
         ST_DISPATCH: begin
            if (hs_any && issued_d == total_q) begin
               state_d = ST_DRAIN;
            end else if (valid_d == '0) begin
               offer_en = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (done_q == total_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The template comes straight from the port on the launch cycle so the
      // first offer is visible the cycle right after the handshake.
      offer_ctx          = (state_q == ST_IDLE) ? kernel_ctx : tmpl_q;
      offer_ctx.cta_id.x = CTA_DIM_W'(cur_x_d);
      offer_ctx.cta_id.y = CTA_DIM_W'(cur_y_d);
      offer_ctx.cta_id.z = CTA_DIM_W'(cur_z_d);

      // Round-robin search from the updated pointer, judged on next-cycle credit
      // so a freed slot can be offered immediately.
      if (offer_en) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            if (!found && out_d[(int'(rr_d) + k) % NUM_CORES] < OUT_MAX) begin
               found    = 1'b1;
               sel_core = (int'(rr_d) + k) % NUM_CORES;
            end
         end
         if (found) begin
            valid_d[sel_core] = 1'b1;
            ctx_d[sel_core]   = offer_ctx;
         end
      end
   end

   // NOTE: all state updates use non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         dim_x_q  <= '0;
         dim_y_q  <= '0;
         dim_z_q  <= '0;
         cur_x_q  <= '0;
         cur_y_q  <= '0;
         cur_z_q  <= '0;
         total_q  <= '0;
         issued_q <= '0;
         done_q   <= '0;
         rr_q     <= '0;
         valid_q  <= '0;
         tmpl_q   <= '0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         kdone_q  <= 1'b0;
         // NOTE: the per-core counter and descriptor arrays are small register
         // banks driving ports, not RAM, so they are reset like any other flop.
         for (int i = 0; i < NUM_CORES; i++) begin
            out_q[i] <= '0;
            ctx_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         dim_x_q  <= dim_x_d;
         dim_y_q  <= dim_y_d;
         dim_z_q  <= dim_z_d;
         cur_x_q  <= cur_x_d;
         cur_y_q  <= cur_y_d;
         cur_z_q  <= cur_z_d;
         total_q  <= total_d;
         issued_q <= issued_d;
         done_q   <= done_d;
         rr_q     <= rr_d;
         valid_q  <= valid_d;
         tmpl_q   <= tmpl_d;
         err_q    <= err_d;
         ready_q  <= (state_d == ST_IDLE);
         busy_q   <= (state_d != ST_IDLE);
         kdone_q  <= (state_d == ST_DONE);
         out_q    <= out_d;
         ctx_q    <= ctx_d;
      end
   end

   assign kernel_start_ready = ready_q;
   assign sm_grant_valid     = valid_q;
   assign sm_grant_ctx       = ctx_q;
   assign sm_done_ready      = '1;
   assign busy               = busy_q;
   assign kernel_done        = kdone_q;
   assign err_spurious_done  = err_q;

endmodule

// File: tb/tb_cta_grid_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_cta_grid_dispatcher
//
// Purpose:
//   Directed bench for cta_grid_dispatcher (4 cores, 2 credits per core).
//   Inputs change 1 time unit after the rising edge; outputs are checked at the
//   same point, i.e. they reflect the registers updated by the preceding edge.
//   The expected round-robin pointer is tracked by hand in exp_rr.
// -----------------------------------------------------------------------------

module tb_cta_grid_dispatcher;
   import dice_pkg::*;

   localparam int NC = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           kernel_start_valid;
   logic           kernel_start_ready;
   logic [15:0]    grid_dim_x, grid_dim_y, grid_dim_z;
   dice_cta_desc_t kernel_ctx;
   logic [NC-1:0]  sm_grant_valid;
   logic [NC-1:0]  sm_grant_ready;
   dice_cta_desc_t sm_grant_ctx [NC];
   logic [NC-1:0]  sm_done_valid;
   logic [NC-1:0]  sm_done_ready;
   dice_cta_id_t   sm_done_cta_id [NC];
   logic           busy, kernel_done, err_spurious_done;

   int             vectors = 0;
   int             miscompares = 0;
   int             exp_rr;
   int             c;
   logic [NC-1:0]  ev;

   always #5 clk = ~clk;

   cta_grid_dispatcher #(
      .NUM_CORES (NC),
      .MAX_CTA   (2),
      .DIM_W     (16)
   ) u_dut (
      .clk                (clk),
      .rst                (rst),
      .kernel_start_valid (kernel_start_valid),
      .kernel_start_ready (kernel_start_ready),
      .grid_dim_x         (grid_dim_x),
      .grid_dim_y         (grid_dim_y),
      .grid_dim_z         (grid_dim_z),
      .kernel_ctx         (kernel_ctx),
      .sm_grant_valid     (sm_grant_valid),
      .sm_grant_ready     (sm_grant_ready),
      .sm_grant_ctx       (sm_grant_ctx),
      .sm_done_valid      (sm_done_valid),
      .sm_done_ready      (sm_done_ready),
      .sm_done_cta_id     (sm_done_cta_id),
      .busy               (busy),
      .kernel_done        (kernel_done),
      .err_spurious_done  (err_spurious_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Start handshake: ready is expected high; the edge inside tick() accepts it.
   task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      grid_dim_x         = x;
      grid_dim_y         = y;
      grid_dim_z         = z;
      kernel_start_valid = 1'b1;
      tick();
      kernel_start_valid = 1'b0;
   endtask

   function automatic logic [63:0] id3(input int x, input int y, input int z);
      return {16'h0, 16'(z), 16'(y), 16'(x)};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst                = 1'b1;
      kernel_start_valid = 1'b0;
      grid_dim_x         = '0;
      grid_dim_y         = '0;
      grid_dim_z         = '0;
      kernel_ctx         = '0;
      sm_grant_ready     = '1;
      sm_done_valid      = '0;
      for (int i = 0; i < NC; i++) sm_done_cta_id[i] = '0;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_valid", 64'(sm_grant_valid), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_kdone", 64'(kernel_done), 64'h0);
      check("rst_err", 64'(err_spurious_done), 64'h0);
      check("rst_ready", 64'(kernel_start_ready), 64'h0);
      check("rst_done_ready", 64'(sm_done_ready), 64'hF);
      for (int i = 0; i < NC; i++) check("rst_ctx", 64'(sm_grant_ctx[i].cta_id), 64'h0);
      rst = 1'b0;
      tick();
      check("rst_ready_after", 64'(kernel_start_ready), 64'h1);
      exp_rr = 0;

      // ---------------- test 1: 2x1x1 ----------------
      kernel_ctx.kernel_id = 32'hABCD_0001;
      kernel_ctx.arg_base  = 32'h0000_1234;
      kernel_ctx.cta_id    = '1;
      launch(2, 1, 1);
      check("t1_valid0", 64'(sm_grant_valid), 64'h1);
      check("t1_id0", 64'(sm_grant_ctx[0].cta_id), id3(0, 0, 0));
      check("t1_kid0", 64'(sm_grant_ctx[0].kernel_id), 64'hABCD_0001);
      check("t1_arg0", 64'(sm_grant_ctx[0].arg_base), 64'h1234);
      check("t1_busy", 64'(busy), 64'h1);
      check("t1_ready", 64'(kernel_start_ready), 64'h0);
      tick();
      check("t1_valid1", 64'(sm_grant_valid), 64'h2);
      check("t1_id1", 64'(sm_grant_ctx[1].cta_id), id3(1, 0, 0));
      tick();
      check("t1_drain_valid", 64'(sm_grant_valid), 64'h0);
      tick();
      tick();
      tick();
      check("t1_no_early_done", 64'(kernel_done), 64'h0);
      sm_done_valid = 4'b0011;
      tick();
      sm_done_valid = '0;
      check("t1_kdone_wait", 64'(kernel_done), 64'h0);
      tick();
      check("t1_kdone", 64'(kernel_done), 64'h1);
      tick();
      check("t1_kdone_end", 64'(kernel_done), 64'h0);
      check("t1_idle_busy", 64'(busy), 64'h0);
      check("t1_idle_ready", 64'(kernel_start_ready), 64'h1);
      exp_rr = 2;

      // ---------------- test 2: 3x2x2, x fastest ----------------
      kernel_ctx.kernel_id = 32'h0000_0002;
      launch(3, 2, 2);
      for (int n = 0; n < 12; n++) begin
         c  = (exp_rr + n) % NC;
         ev = 4'b0001 << c;
         check("t2_valid", 64'(sm_grant_valid), 64'(ev));
         check("t2_id", 64'(sm_grant_ctx[c].cta_id), id3(n % 3, (n / 3) % 2, n / 6));
         sm_done_valid = (n > 0) ? (4'b0001 << ((exp_rr + n - 1) % NC)) : 4'b0000;
         tick();
      end
      sm_done_valid = 4'b0001 << ((exp_rr + 11) % NC);
      check("t2_drain_valid", 64'(sm_grant_valid), 64'h0);
      tick();
      sm_done_valid = '0;
      check("t2_kdone_wait", 64'(kernel_done), 64'h0);
      tick();
      check("t2_kdone", 64'(kernel_done), 64'h1);
      tick();
      check("t2_kdone_end", 64'(kernel_done), 64'h0);
      check("t2_idle_busy", 64'(busy), 64'h0);
      check("t2_err", 64'(err_spurious_done), 64'h0);
      exp_rr = (exp_rr + 12) % NC;

      // ---------------- test 3: credit limit (2 per core) ----------------
      launch(10, 1, 1);
      for (int n = 0; n < 8; n++) begin
         c  = (exp_rr + n) % NC;
         ev = 4'b0001 << c;
         check("t3_valid", 64'(sm_grant_valid), 64'(ev));
         check("t3_id", 64'(sm_grant_ctx[c].cta_id), id3(n, 0, 0));
         tick();
      end
      check("t3_stall0", 64'(sm_grant_valid), 64'h0);
      tick();
      check("t3_stall1", 64'(sm_grant_valid), 64'h0);
      tick();
      check("t3_stall2", 64'(sm_grant_valid), 64'h0);
      sm_done_valid = 4'b0001;
      tick();
      sm_done_valid = '0;
      check("t3_freed_valid", 64'(sm_grant_valid), 64'h1);
      check("t3_freed_id", 64'(sm_grant_ctx[0].cta_id), id3(8, 0, 0));
      tick();
      check("t3_stall3", 64'(sm_grant_valid), 64'h0);
      sm_done_valid = 4'b0010;
      tick();
      sm_done_valid = '0;
      check("t3_last_valid", 64'(sm_grant_valid), 64'h2);
      check("t3_last_id", 64'(sm_grant_ctx[1].cta_id), id3(9, 0, 0));
      tick();
      check("t3_drain_valid", 64'(sm_grant_valid), 64'h0);
      check("t3_drain_busy", 64'(busy), 64'h1);
      sm_done_valid = 4'b1111;
      tick();
      tick();
      sm_done_valid = '0;
      check("t3_kdone_wait", 64'(kernel_done), 64'h0);
      tick();
      check("t3_kdone", 64'(kernel_done), 64'h1);
      tick();
      check("t3_idle_busy", 64'(busy), 64'h0);
      check("t3_err", 64'(err_spurious_done), 64'h0);
      exp_rr = 2;

      // ---------------- test 6: reset mid-dispatch ----------------
      launch(3, 3, 1);
      check("t6_valid0", 64'(sm_grant_valid), 64'h4);
      tick();
      check("t6_valid1", 64'(sm_grant_valid), 64'h8);
      rst = 1'b1;
      tick();
      check("t6_rst_valid", 64'(sm_grant_valid), 64'h0);
      check("t6_rst_busy", 64'(busy), 64'h0);
      check("t6_rst_kdone", 64'(kernel_done), 64'h0);
      rst = 1'b0;
      tick();
      check("t6_ready", 64'(kernel_start_ready), 64'h1);
      exp_rr = 0;

      // ---------------- test 4: relaunch, core0 holds off 7 cycles ----------------
      kernel_ctx.kernel_id = 32'h600D_0006;
      sm_grant_ready       = 4'b1110;
      launch(2, 1, 1);
      for (int n = 0; n < 7; n++) begin
         check("t4_hold_valid", 64'(sm_grant_valid), 64'h1);
         check("t4_hold_id", 64'(sm_grant_ctx[0].cta_id), id3(0, 0, 0));
         check("t4_hold_kid", 64'(sm_grant_ctx[0].kernel_id), 64'h600D_0006);
         tick();
      end
      check("t4_still_valid", 64'(sm_grant_valid), 64'h1);
      sm_grant_ready = 4'b1111;
      tick();
      check("t4_next_valid", 64'(sm_grant_valid), 64'h2);
      check("t4_next_id", 64'(sm_grant_ctx[1].cta_id), id3(1, 0, 0));
      tick();
      check("t4_drain_valid", 64'(sm_grant_valid), 64'h0);
      sm_done_valid = 4'b0011;
      tick();
      sm_done_valid = '0;
      tick();
      check("t4_kdone", 64'(kernel_done), 64'h1);
      tick();
      check("t4_idle_busy", 64'(busy), 64'h0);
      check("t4_err", 64'(err_spurious_done), 64'h0);

      // ---------------- test 5: zero grid, spurious done ----------------
      launch(0, 4, 1);
      check("t5_kdone", 64'(kernel_done), 64'h1);
      check("t5_valid", 64'(sm_grant_valid), 64'h0);
      tick();
      check("t5_kdone_end", 64'(kernel_done), 64'h0);
      check("t5_valid_after", 64'(sm_grant_valid), 64'h0);
      check("t5_idle_busy", 64'(busy), 64'h0);
      check("t5_ready", 64'(kernel_start_ready), 64'h1);
      // Core 2 had a CTA outstanding before the reset; it must now count as spurious.
      sm_done_valid = 4'b0100;
      tick();
      sm_done_valid = '0;
      check("t5_err_set", 64'(err_spurious_done), 64'h1);
      tick();
      tick();
      check("t5_err_sticky", 64'(err_spurious_done), 64'h1);
      check("t5_busy_after_err", 64'(busy), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
